param_bcd_timer: RTL and testbench
==================================

# param_bcd_timer

Single-clock, parametrised BCD up/down timer core replacing the ripple-clocked divider chain and cascaded digit counters of the 60-second timer. An internal clock-enable prescaler derives the count rate from `CLOCK_50`, and all flops run on one clock. The digit chain supports N digits, decimal or MM:SS modulo, parallel load, wrap or saturate-with-done, and pulse outputs. The block sits between the board switches/keys and the per-digit 7-segment decoders.

## Interface
- `CLK_HZ`, 50000000: input clock frequency.
- `TICK_HZ`, 1: count rate. `DIV = CLK_HZ/TICK_HZ`, must be ≥ 2.
- `NUM_DIGITS`, 4: number of BCD digits, 1–8.
- `MMSS_MODE`, 1: if 1, digits 1 and 3 count modulo 6 (max 59:59). If 0, all digits count modulo 10.
- `CLOCK_50` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Direction` in 1: 1 = count up, 0 = count down. Sampled every cycle.
- `Hold` in 1: 1 freezes the prescaler and the digits.
- `WrapEn` in 1: 1 = wrap at terminal value, 0 = saturate and raise `Done`.
- `Load` in 1: synchronous parallel load strobe.
- `LoadValue` in 4*NUM_DIGITS: BCD load value; digit 0 occupies bits [3:0].
- `Digits` out 4*NUM_DIGITS: current BCD count, same packing as `LoadValue`.
- `Tick` out 1: one-cycle pulse on each count event.
- `Overflow` out 1: one-cycle pulse on each wrap.
- `Done` out 1: sticky saturation flag.

## Operation
- Digit max: `MAXd` = 5 for d∈{1,3} when `MMSS_MODE`=1, otherwise 9. The terminal value is all-max when counting up and all-zero when counting down.
- Prescaler: counter of width `$clog2(DIV)`. A tick event fires when the counter equals DIV-1; the counter then returns to 0.
- Priority per cycle: `Reset` > `Load` > `Done` > `Hold` > count.
- `Load`:
  - Each digit is loaded with min(LoadValue digit, `MAXd`); values above max are clamped.
  - The prescaler and `Done` clear.
  - No `Tick` is generated.
- Count on a tick event, when `Done`=0 and `Hold`=0:
  - Up: digit 0 increments. A digit at `MAXd` becomes 0 and carries into the next digit.
  - Down: digit 0 decrements. A digit at 0 becomes `MAXd` and borrows from the next digit.
- Terminal event: a tick event while `Digits` already equals the terminal value for the current `Direction`.
  - `WrapEn`=1: up wraps to all-zero, down wraps to all-max. `Overflow` pulses.
  - `WrapEn`=0: `Digits` is unchanged, `Done` is set, and `Tick` still pulses.
- While `Done`=1: the prescaler and digits are frozen. Only `Load` or `Reset` clears `Done`.
- `Direction` changes mid-count take effect at the next tick. The prescaler phase is preserved.
- `Hold` does not clear the prescaler. Counting resumes from the held phase.

## Timing
- Reset values: `Digits`=0, `Tick`=0, `Overflow`=0, `Done`=0, prescaler=0.
- Reset is asynchronous assert and synchronous release. Reset mid-count aborts immediately, with no partial carry.
- The prescaler reaches DIV-1 in cycle N. In cycle N+1, `Digits` shows the new value and `Tick` (plus `Overflow` if wrapping) is 1 for exactly that cycle.
- First tick: `Tick` first asserts DIV cycles after the first clock edge following reset release or `Load`.
- `Done` rises in the same cycle as the terminal `Tick` and stays high.
- `Load` takes effect on the next edge (1-cycle latency). If `Load` and a tick event coincide, the load wins and no tick is emitted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `timer_pkg`: constant `BCD_W`=4, function `digit_max(idx, mmss)`, and function `prescale_w(clk_hz, tick_hz)`.
- Sub-module `bcd_digit_counter`, one instance per digit in a generate loop:
  - Inputs: `en`, `up`, `load`, `load_val`, `max`.
  - Outputs: the digit, plus combinational `at_max`/`at_zero` for carry/borrow and terminal detection.
- Top level: prescaler, enable chain (digit d is enabled when all lower digits are at their roll-over value), terminal detect, and output pulse registers.

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), NUM_DIGITS=4, MMSS_MODE=1.
- Release `Reset`, Up, `WrapEn`=1 -> `Tick` pulses every 10 cycles. The first pulse is 10 cycles after release, and `Digits` reaches 0x0001 at that pulse.
- `Load` 0x0959, Up, `WrapEn`=1 -> the next tick gives 0x1000. `Load` 0x5959 -> the next tick gives 0x0000 with `Overflow`=1 for one cycle.
- `Load` 0x0003, Down, `WrapEn`=0 -> 0x0002, 0x0001, 0x0000. The following tick holds 0x0000 with `Done`=1 and `Tick`=1. `Done` stays high until `Load`.
- `Load` 0x9F7C -> `Digits`=0x5959 (each digit clamped to its max).
- `Hold` asserted for 25 cycles mid-interval -> no `Tick` during the hold. The next `Tick` arrives after the remaining prescaler count, not after a full DIV.
- `Reset` pulsed 3 cycles after a tick -> all outputs are 0 immediately (asynchronously). `Load` coincident with a tick event -> the load value appears and `Tick`=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the BCD timer: digit width, per-digit
// modulus and prescaler counter sizing.
// Pure compile-time content, no logic.
package timer_pkg;

  localparam int BCD_W = 4;

  // Highest value a digit may hold: tens-of-seconds and tens-of-minutes
  // positions stop at 5 in MM:SS mode, everything else is decimal.
  function automatic logic [BCD_W-1:0] digit_max(input int idx, input bit mmss);
    if (mmss && (idx == 1 || idx == 3)) begin
      return 4'd5;
    end
    return 4'd9;
  endfunction

  // Width of the prescaler counter that runs 0..DIV-1 (at least 1 bit).
  function automatic int prescale_w(input int clk_hz, input int tick_hz);
    int div;
    div = clk_hz / tick_hz;
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with parallel load (clamped to max), up/down step on en.
// Digit register updates on the edge after en/load; at_max/at_zero are
// combinational decodes of the stored digit for the carry chain.
module bcd_digit_counter
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] digit,
  output logic             at_max,
  output logic             at_zero
);

  assign at_max  = (digit == max);
  assign at_zero = (digit == '0);

  // Load clamps out-of-range values; a step rolls over at max/zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= (load_val > max) ? max : load_val;
    end else if (en) begin
      if (up) begin
        digit <= at_max ? '0 : digit + 4'd1;
      end else begin
        digit <= at_zero ? max : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/param_bcd_timer.sv
// N-digit BCD up/down timer with clock-enable prescaler, load, wrap/saturate.
// Digits/Tick/Overflow/Done update one cycle after the prescaler reaches DIV-1.
// Hold and Done freeze prescaler phase and digits; Load always wins.
module param_bcd_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_DIGITS = 4,
  parameter int MMSS_MODE  = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        Reset,
  input  logic                        Direction,
  input  logic                        Hold,
  input  logic                        WrapEn,
  input  logic                        Load,
  input  logic [BCD_W*NUM_DIGITS-1:0] LoadValue,
  output logic [BCD_W*NUM_DIGITS-1:0] Digits,
  output logic                        Tick,
  output logic                        Overflow,
  output logic                        Done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = prescale_w(CLK_HZ, TICK_HZ);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0]         cnt;
  logic                  tick_evt;
  logic                  count_step;
  logic                  terminal;
  logic                  stall;
  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] roll;
  logic [NUM_DIGITS-1:0] en;

  assign tick_evt   = (cnt == LAST);
  assign count_step = tick_evt && !Load && !Done && !Hold;
  assign terminal   = Direction ? (&at_max) : (&at_zero);
  // Saturating terminal tick: digits stay put, only Done/Tick react.
  assign stall      = terminal && !WrapEn;
  assign roll       = Direction ? at_max : at_zero;

  // Prescaler: cleared by load, frozen by Done or Hold, otherwise free-running.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (Load) begin
      cnt <= '0;
    end else if (!Done && !Hold) begin
      cnt <= tick_evt ? '0 : cnt + PW'(1);
    end
  end

  // Ripple-free enable chain: digit d steps when every lower digit rolls over.
  always_comb begin
    logic run;
    en  = '0;
    run = count_step && !stall;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en[i] = run;
      run   = run && roll[i];
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    localparam logic [BCD_W-1:0] MAXD = digit_max(d, MMSS_MODE != 0);
    bcd_digit_counter u_digit (
      .clk      (CLOCK_50),
      .rst      (Reset),
      .en       (en[d]),
      .up       (Direction),
      .load     (Load),
      .load_val (LoadValue[d*BCD_W +: BCD_W]),
      .max      (MAXD),
      .digit    (Digits[d*BCD_W +: BCD_W]),
      .at_max   (at_max[d]),
      .at_zero  (at_zero[d])
    );
  end

  // Registered event pulses and the sticky saturation flag.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      Tick     <= 1'b0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Tick     <= count_step;
      Overflow <= count_step && terminal && WrapEn;
      if (Load) begin
        Done <= 1'b0;
      end else if (count_step && stall) begin
        Done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_bcd_timer.sv
// Bench for param_bcd_timer in MM:SS mode, DIV=10: directed scenarios then
// random traffic, all compared each cycle against a seconds-based model.
module tb_param_bcd_timer;

  localparam int DIV = 10;
  localparam int MOD = 3600;

  logic        clk = 1'b0;
  logic        rst;
  logic        dir;
  logic        hold;
  logic        wrap;
  logic        load;
  logic [15:0] lv;
  logic [15:0] digits;
  logic        tick;
  logic        ovf;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Model state: count as total seconds, prescaler phase as elapsed cycles.
  int m_v;
  int m_ph;
  bit m_done;
  bit m_tick;
  bit m_ovf;

  always #5 clk = ~clk;

  param_bcd_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .NUM_DIGITS(4), .MMSS_MODE(1)
  ) dut (
    .CLOCK_50  (clk),
    .Reset     (rst),
    .Direction (dir),
    .Hold      (hold),
    .WrapEn    (wrap),
    .Load      (load),
    .LoadValue (lv),
    .Digits    (digits),
    .Tick      (tick),
    .Overflow  (ovf),
    .Done      (done)
  );

  function automatic logic [15:0] to_bcd(input int v);
    int mm;
    int ss;
    mm = v / 60;
    ss = v % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int clamp_dig(input logic [3:0] x, input int mx);
    return (int'(x) > mx) ? mx : int'(x);
  endfunction

  function automatic int from_load(input logic [15:0] x);
    int d0, d1, d2, d3;
    d0 = clamp_dig(x[3:0], 9);
    d1 = clamp_dig(x[7:4], 5);
    d2 = clamp_dig(x[11:8], 9);
    d3 = clamp_dig(x[15:12], 5);
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_ph = 0; m_done = 0; m_tick = 0; m_ovf = 0;
  endtask

  // One clock of behaviour from the timer's rules, inputs as seen at the edge.
  task automatic model_step();
    bit term;
    m_tick = 0;
    m_ovf  = 0;
    if (rst) begin
      model_reset();
    end else if (load) begin
      m_v = from_load(lv); m_ph = 0; m_done = 0;
    end else if (m_done || hold) begin
      // frozen
    end else if (m_ph == DIV - 1) begin
      m_ph   = 0;
      m_tick = 1;
      term   = dir ? (m_v == MOD - 1) : (m_v == 0);
      if (term && !wrap) m_done = 1;
      else begin
        if (term) m_ovf = 1;
        m_v = dir ? (m_v + 1) % MOD : (m_v + MOD - 1) % MOD;
      end
    end else begin
      m_ph++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("digits", digits, to_bcd(m_v));
    check("tick", tick, m_tick);
    check("overflow", ovf, m_ovf);
    check("done", done, m_done);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick && n < 200);
    check("tick_timeout", tick, 1);
  endtask

  initial begin
    int n;
    rst = 1; dir = 1; hold = 0; wrap = 1; load = 0; lv = '0;
    model_reset();
    #1;
    check("reset_digits", digits, 16'h0000);
    check("reset_tick", tick, 0);
    check("reset_done", done, 0);
    cyc(); cyc();
    rst = 0;

    // First tick latency after reset release, then steady counting.
    wait_tick(n);
    check("first_tick_lat", n, DIV);
    check("first_tick_val", digits, 16'h0001);
    repeat (25) cyc();

    // Carry across MM:SS boundary, then full wrap with Overflow.
    load = 1; lv = 16'h0959; cyc(); load = 0;
    wait_tick(n);
    check("carry_0959", digits, 16'h1000);
    load = 1; lv = 16'h5959; cyc(); load = 0;
    wait_tick(n);
    check("wrap_val", digits, 16'h0000);
    check("wrap_ovf", ovf, 1);
    cyc();
    check("ovf_pulse", ovf, 0);

    // Count down into saturation; Done is sticky until the next load.
    dir = 0; wrap = 0;
    load = 1; lv = 16'h0003; cyc(); load = 0;
    repeat (45) cyc();
    check("sat_done", done, 1);
    check("sat_val", digits, 16'h0000);

    // Clamped load clears Done.
    load = 1; lv = 16'h9F7C; cyc(); load = 0;
    check("clamp_val", digits, 16'h5959);
    check("clamp_done", done, 0);

    // Hold mid-interval preserves the prescaler phase.
    dir = 1; wrap = 1;
    wait_tick(n);
    repeat (4) cyc();
    hold = 1;
    repeat (25) begin
      cyc();
      check("hold_no_tick", tick, 0);
    end
    hold = 0;
    wait_tick(n);
    check("hold_resume_lat", n, DIV - 4);

    // Asynchronous reset three cycles after a tick.
    wait_tick(n);
    repeat (3) cyc();
    #2 rst = 1;
    #1;
    check("arst_digits", digits, 16'h0000);
    check("arst_tick", tick, 0);
    check("arst_ovf", ovf, 0);
    check("arst_done", done, 0);
    model_reset();
    cyc(); cyc();
    rst = 0;

    // Load coincident with a tick event wins and suppresses Tick.
    n = 0;
    while (m_ph != DIV - 1 && n < 20) begin
      cyc();
      n++;
    end
    check("coinc_phase", m_ph, DIV - 1);
    load = 1; lv = 16'h1234; cyc(); load = 0;
    check("coinc_val", digits, 16'h1234);
    check("coinc_tick", tick, 0);

    // Random mix of direction, hold, wrap and loads.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 99) < 3);
      lv   = 16'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) dir  = ~dir;
      if ($urandom_range(0, 29) == 0) wrap = ~wrap;
      if ($urandom_range(0, 59) == 0) begin
        load = 1;
        lv   = $urandom_range(0, 1) ? 16'h5958 : 16'h0001;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
